// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
//   Shared definitions for the pipeline control unit: stall bit meaning,
//   stall bit positions, the stall vector encodings produced for each
//   requesting stage, the controller state encoding and the registered
//   controller state struct.
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

    // Per-bit stall meaning: a register whose bit is STOP holds its value.
    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam int unsigned STALL_W = 6;

    // Bit positions inside stall_o.
    localparam int unsigned STALL_BIT_PC    = 0;
    localparam int unsigned STALL_BIT_IF_ID = 1;
    localparam int unsigned STALL_BIT_ID_EX = 2;
    localparam int unsigned STALL_BIT_EX_MEM = 3;
    localparam int unsigned STALL_BIT_MEM_WB = 4;
    localparam int unsigned STALL_BIT_WB    = 5;

    // A requesting stage and everything upstream of it holds; the register
    // directly downstream takes a bubble.
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
    localparam logic [STALL_W-1:0] STALL_NONE = {STALL_W{NO_STOP}};

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    // Complete registered controller state, kept in one struct so it can be
    // observed as a unit.
    typedef struct packed {
        state_e     state;
        logic [3:0] fcnt;
    } ctrl_t;

    // Highest stage wins.
    function automatic logic [STALL_W-1:0] stall_vec(input logic req_if,
                                                     input logic req_id,
                                                     input logic req_ex,
                                                     input logic req_mem);
        logic [STALL_W-1:0] v;
        v = STALL_NONE;
        if (req_mem)     v = STALL_MEM;
        else if (req_ex) v = STALL_EX;
        else if (req_id) v = STALL_ID;
        else if (req_if) v = STALL_IF;
        return v;
    endfunction

endpackage

// File: rtl/pipe_ctrl_perf.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_perf
//   Saturating performance counter bank for pipe_ctrl (instantiated only when
//   PIPE_CTRL_PERF_EN is defined).
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset (clears all)
//   stall_active_i         current cycle has a non-zero stall vector
//   redirect_i             redirect strobe this cycle
//   trap_i                 trap strobe this cycle
//   perf_stall_cyc_o       stalled-cycle count
//   perf_flush_evt_o       redirect event count
//   perf_trap_evt_o        trap event count
// ---------------------------------------------------------------------------
module pipe_ctrl_perf #(
    parameter int unsigned PERF_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_active_i,
    input  logic              redirect_i,
    input  logic              trap_i,
    output logic [PERF_W-1:0] perf_stall_cyc_o,
    output logic [PERF_W-1:0] perf_flush_evt_o,
    output logic [PERF_W-1:0] perf_trap_evt_o
);

    logic [PERF_W-1:0] stall_q, stall_d;
    logic [PERF_W-1:0] flush_q, flush_d;
    logic [PERF_W-1:0] trap_q,  trap_d;

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        trap_d  = trap_q;
        if (stall_active_i && (stall_q != '1)) stall_d = stall_q + 1'b1;
        if (redirect_i     && (flush_q != '1)) flush_d = flush_q + 1'b1;
        if (trap_i         && (trap_q  != '1)) trap_d  = trap_q  + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= '0;
            flush_q <= '0;
            trap_q  <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
            trap_q  <= trap_d;
        end
    end

    assign perf_stall_cyc_o = stall_q;
    assign perf_flush_evt_o = flush_q;
    assign perf_trap_evt_o  = trap_q;

endmodule

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
//   Pipeline control unit. Merges stage stall requests into a 6-bit stall
//   vector and sequences flushes / PC redirects for EX branch mispredicts,
//   MEM exceptions and mret, holding flush for FLUSH_CYCLES cycles.
//   Optional feature macro: PIPE_CTRL_PERF_EN (adds perf_* counter outputs).
// Parameters:
//   FLUSH_CYCLES  cycles flush_o is held per redirect event (1..15)
//   PERF_W        perf counter width
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   stallreq_{if,id,ex,mem}_i     stage stall requests
//   branch_redirect_i/target_i    EX mispredict and correct PC
//   exc_valid_i/cause_i/pc_i      MEM exception
//   mret_i, mtvec_i, mepc_i       mret retire and trap CSRs
//   stall_o                       stall vector (1 = stop), bit0 PC .. bit5 WB
//   flush_o                       flush all pipeline registers
//   redirect_valid_o/pc_o         PC load strobe and value
//   trap_o/cause_o/epc_o          trap record strobe and values
//   perf_*_o                      counters (PIPE_CTRL_PERF_EN only)
// ---------------------------------------------------------------------------
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned PERF_W       = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               stallreq_if_i,
    input  logic               stallreq_id_i,
    input  logic               stallreq_ex_i,
    input  logic               stallreq_mem_i,
    input  logic               branch_redirect_i,
    input  logic [31:0]        branch_target_i,
    input  logic               exc_valid_i,
    input  logic [31:0]        exc_cause_i,
    input  logic [31:0]        exc_pc_i,
    input  logic               mret_i,
    input  logic [31:0]        mtvec_i,
    input  logic [31:0]        mepc_i,
    output logic [STALL_W-1:0] stall_o,
    output logic               flush_o,
    output logic               redirect_valid_o,
    output logic [31:0]        redirect_pc_o,
    output logic               trap_o,
    output logic [31:0]        trap_cause_o,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0]        trap_epc_o,
    output logic [PERF_W-1:0]  perf_stall_cyc_o,
    output logic [PERF_W-1:0]  perf_flush_evt_o,
    output logic [PERF_W-1:0]  perf_trap_evt_o
`else
    output logic [31:0]        trap_epc_o
`endif
);

    if ((FLUSH_CYCLES < 1) || (FLUSH_CYCLES > 15) || (PERF_W < 1)) begin : g_bad_param
        $error("pipe_ctrl: FLUSH_CYCLES must be 1..15 and PERF_W >= 1");
    end

    // fcnt counts the flush cycles still owed after the next one.
    localparam logic [3:0] FCNT_RELOAD = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;

    ctrl_t ctrl_q, ctrl_d;

    logic mret_take, exc_take, br_take, evt_take;

    // A MEM stall blocks MEM events; the instruction simply waits in MEM.
    // Branches additionally need EX unstalled and are ignored while flushing.
    assign mret_take = mret_i && !stallreq_mem_i;
    assign exc_take  = exc_valid_i && !stallreq_mem_i && !mret_take;
    assign br_take   = (ctrl_q.state == ST_RUN) && branch_redirect_i &&
                       !stallreq_mem_i && !stallreq_ex_i && !mret_take && !exc_take;
    assign evt_take  = mret_take || exc_take || br_take;

    always_comb begin
        ctrl_d           = ctrl_q;
        stall_o          = STALL_NONE;
        flush_o          = 1'b0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = 32'h0;
        trap_o           = 1'b0;
        trap_cause_o     = 32'h0;
        trap_epc_o       = 32'h0;

        if (evt_take) begin
            flush_o          = 1'b1;
            redirect_valid_o = 1'b1;
            if (mret_take) begin
                redirect_pc_o = mepc_i;
            end else if (exc_take) begin
                redirect_pc_o = {mtvec_i[31:2], 2'b00};
                trap_o        = 1'b1;
                trap_cause_o  = exc_cause_i;
                trap_epc_o    = exc_pc_i;
            end else begin
                redirect_pc_o = branch_target_i;
            end
            if (FLUSH_CYCLES > 1) begin
                ctrl_d.state = ST_FLUSH;
                ctrl_d.fcnt  = FCNT_RELOAD;
            end else begin
                ctrl_d.state = ST_RUN;
                ctrl_d.fcnt  = 4'd0;
            end
        end else if (ctrl_q.state == ST_FLUSH) begin
            flush_o = 1'b1;
            if (ctrl_q.fcnt == 4'd0) begin
                ctrl_d.state = ST_RUN;
            end else begin
                ctrl_d.fcnt = ctrl_q.fcnt - 4'd1;
            end
        end else begin
            stall_o = stall_vec(stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i);
        end

        // Nothing leaves the block while reset is asserted.
        if (rst_i) begin
            stall_o          = STALL_NONE;
            flush_o          = 1'b0;
            redirect_valid_o = 1'b0;
            redirect_pc_o    = 32'h0;
            trap_o           = 1'b0;
            trap_cause_o     = 32'h0;
            trap_epc_o       = 32'h0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q.state <= ST_RUN;
            ctrl_q.fcnt  <= 4'd0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    pipe_ctrl_perf #(
        .PERF_W (PERF_W)
    ) u_perf (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .stall_active_i   (|stall_o),
        .redirect_i       (redirect_valid_o),
        .trap_i           (trap_o),
        .perf_stall_cyc_o (perf_stall_cyc_o),
        .perf_flush_evt_o (perf_flush_evt_o),
        .perf_trap_evt_o  (perf_trap_evt_o)
    );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl
//   Drives two pipe_ctrl instances (FLUSH_CYCLES = 1 and 3) with the same
//   inputs and compares every output each cycle against a reference model
//   that tracks only "flush cycles still owed" per instance.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic        rv;
    logic [31:0] pc;
    logic        trap;
    logic [31:0] cause;
    logic [31:0] epc;
  } exp_t;
  localparam int W = $bits(exp_t);

  logic        clk, rst;
  logic        sr_if, sr_id, sr_ex, sr_mem;
  logic        br;
  logic [31:0] br_tgt;
  logic        exc;
  logic [31:0] exc_cause, exc_pc;
  logic        mret;
  logic [31:0] mtvec, mepc;

  logic [5:0]  stall_w [2];
  logic        flush_w [2];
  logic        rv_w    [2];
  logic [31:0] pc_w    [2];
  logic        trap_w  [2];
  logic [31:0] cause_w [2];
  logic [31:0] epc_w   [2];
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] pst_w [2];
  logic [31:0] pfl_w [2];
  logic [31:0] ptr_w [2];
  int unsigned m_pst [2];
  int unsigned m_pfl [2];
  int unsigned m_ptr [2];
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [W-1:0] exp_q[$];

  // Model state: flush cycles still owed after the current one.
  int fc [2] = '{1, 3};
  int rem [2];

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUTs ----------------
  for (genvar g = 0; g < 2; g++) begin : g_dut
    pipe_ctrl #(.FLUSH_CYCLES(g == 0 ? 1 : 3), .PERF_W(32)) u_dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .stallreq_if_i     (sr_if),
      .stallreq_id_i     (sr_id),
      .stallreq_ex_i     (sr_ex),
      .stallreq_mem_i    (sr_mem),
      .branch_redirect_i (br),
      .branch_target_i   (br_tgt),
      .exc_valid_i       (exc),
      .exc_cause_i       (exc_cause),
      .exc_pc_i          (exc_pc),
      .mret_i            (mret),
      .mtvec_i           (mtvec),
      .mepc_i            (mepc),
      .stall_o           (stall_w[g]),
      .flush_o           (flush_w[g]),
      .redirect_valid_o  (rv_w[g]),
      .redirect_pc_o     (pc_w[g]),
      .trap_o            (trap_w[g]),
      .trap_cause_o      (cause_w[g]),
`ifdef PIPE_CTRL_PERF_EN
      .trap_epc_o        (epc_w[g]),
      .perf_stall_cyc_o  (pst_w[g]),
      .perf_flush_evt_o  (pfl_w[g]),
      .perf_trap_evt_o   (ptr_w[g])
`else
      .trap_epc_o        (epc_w[g])
`endif
    );
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic exp_t model_out(input int d);
    exp_t e;
    bit in_flush, t_mret, t_exc, t_br;
    e = '0;
    if (rst) return e;
    in_flush = rem[d] > 0;
    t_mret = mret && !sr_mem;
    t_exc  = exc && !sr_mem && !t_mret;
    t_br   = !in_flush && br && !sr_mem && !sr_ex && !t_mret && !t_exc;
    if (t_mret || t_exc || t_br) begin
      e.flush = 1'b1;
      e.rv    = 1'b1;
      if (t_mret)     e.pc = mepc;
      else if (t_exc) e.pc = mtvec & 32'hFFFF_FFFC;
      else            e.pc = br_tgt;
      if (t_exc) begin
        e.trap  = 1'b1;
        e.cause = exc_cause;
        e.epc   = exc_pc;
      end
    end else if (in_flush) begin
      e.flush = 1'b1;
    end else begin
      // Highest requesting stage and all upstream stages stop.
      if (sr_mem)     e.stall = 6'd31;
      else if (sr_ex) e.stall = 6'd15;
      else if (sr_id) e.stall = 6'd7;
      else if (sr_if) e.stall = 6'd3;
    end
    return e;
  endfunction

  function automatic int next_rem(input int d, input exp_t e);
    if (rst) return 0;
    if (e.rv) return fc[d] - 1;
    if (rem[d] > 0) return rem[d] - 1;
    return 0;
  endfunction

  // Check current cycle, advance model, move to next cycle (+1 after edge).
  task automatic step();
    exp_t e [2];
    exp_t x;
    string s;
    #1;
    for (int d = 0; d < 2; d++) begin
      e[d] = model_out(d);
      exp_q.push_back(W'(e[d]));
    end
    for (int d = 0; d < 2; d++) begin
      x = exp_t'(exp_q.pop_front());
      s = $sformatf("fc%0d", fc[d]);
      check({s, ".stall"}, 32'(stall_w[d]), 32'(x.stall));
      check({s, ".flush"}, 32'(flush_w[d]), 32'(x.flush));
      check({s, ".redirect_valid"}, 32'(rv_w[d]), 32'(x.rv));
      check({s, ".redirect_pc"}, pc_w[d], x.pc);
      check({s, ".trap"}, 32'(trap_w[d]), 32'(x.trap));
      check({s, ".trap_cause"}, cause_w[d], x.cause);
      check({s, ".trap_epc"}, epc_w[d], x.epc);
`ifdef PIPE_CTRL_PERF_EN
      check({s, ".perf_stall"}, pst_w[d], m_pst[d]);
      check({s, ".perf_flush"}, pfl_w[d], m_pfl[d]);
      check({s, ".perf_trap"}, ptr_w[d], m_ptr[d]);
      if (rst) begin
        m_pst[d] = 0; m_pfl[d] = 0; m_ptr[d] = 0;
      end else begin
        if (e[d].stall != 0 && m_pst[d] != 32'hFFFF_FFFF) m_pst[d]++;
        if (e[d].rv && m_pfl[d] != 32'hFFFF_FFFF) m_pfl[d]++;
        if (e[d].trap && m_ptr[d] != 32'hFFFF_FFFF) m_ptr[d]++;
      end
`endif
      rem[d] = next_rem(d, e[d]);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic set_idle();
    sr_if = 0; sr_id = 0; sr_ex = 0; sr_mem = 0;
    br = 0; br_tgt = 32'h0;
    exc = 0; exc_cause = 32'h0; exc_pc = 32'h0;
    mret = 0; mtvec = 32'h0; mepc = 32'h0;
  endtask

  task automatic idle_steps(input int n);
    set_idle();
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drive_random();
    sr_if  = ($urandom_range(0, 3) == 0);
    sr_id  = ($urandom_range(0, 3) == 0);
    sr_ex  = ($urandom_range(0, 4) == 0);
    sr_mem = ($urandom_range(0, 4) == 0);
    br     = ($urandom_range(0, 5) == 0);
    exc    = ($urandom_range(0, 9) == 0);
    mret   = ($urandom_range(0, 11) == 0);
    br_tgt = $urandom; exc_cause = $urandom; exc_pc = $urandom;
    mtvec  = $urandom; mepc = $urandom;
    rst    = ($urandom_range(0, 49) == 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rem = '{0, 0};
`ifdef PIPE_CTRL_PERF_EN
    m_pst = '{0, 0}; m_pfl = '{0, 0}; m_ptr = '{0, 0};
`endif
    rst = 1'b1;
    set_idle();
    @(posedge clk);
    #1;
    step();
    step();
    rst = 1'b0;
    idle_steps(2);

    // Stall priority.
    sr_id = 1; step();
    sr_mem = 1; step();
    sr_id = 0; sr_mem = 0; sr_if = 1; step();
    sr_ex = 1; step();
    idle_steps(1);

    // Branch redirect.
    br = 1; br_tgt = 32'h8000_0040; step();
    idle_steps(4);

    // Exception beats simultaneous branch; mtvec low bits cleared.
    exc = 1; exc_cause = 32'd2; exc_pc = 32'h100; mtvec = 32'h203;
    br = 1; br_tgt = 32'h8000_0040; step();
    idle_steps(4);

    // Exception held behind a MEM stall for 3 cycles, then taken.
    exc = 1; exc_cause = 32'd7; exc_pc = 32'h344; mtvec = 32'h1000; sr_mem = 1;
    for (int i = 0; i < 3; i++) step();
    sr_mem = 0; step();
    idle_steps(4);

    // Branch during flush hold is ignored.
    br = 1; br_tgt = 32'h40; step();
    br = 1; br_tgt = 32'h80; step();
    idle_steps(4);

    // mret during flush hold is taken and extends the flush.
    br = 1; br_tgt = 32'h40; step();
    set_idle(); mret = 1; mepc = 32'h400; step();
    idle_steps(5);

    // Reset in the middle of a flush hold.
    br = 1; br_tgt = 32'hC0; step();
    set_idle(); rst = 1; step();
    rst = 0; idle_steps(3);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      step();
    end
    rst = 0;
    idle_steps(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline control unit; the producing end of the stall/flush interface consumed by the if_id, id_ex, ex_mem and mem_wb pipeline registers.
- Arbitrates stall requests from the IF, ID, EX and MEM stages into a 6-bit stall vector.
- Sequences pipeline flushes and PC redirects on EX-stage branch mispredicts and MEM-stage exceptions/mret, including a multi-cycle flush hold.

Parameters:
- FLUSH_CYCLES, 1, number of consecutive cycles flush_o is held per redirect event; legal range 1..15.
- PERF_W, 32, width of the performance counters (optional feature only).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- stallreq_if_i  in  1  fetch stall request.
- stallreq_id_i  in  1  decode stall request (load-use).
- stallreq_ex_i  in  1  execute stall request (multi-cycle ALU).
- stallreq_mem_i  in  1  memory stall request (bus wait).
- branch_redirect_i  in  1  EX mispredict detected.
- branch_target_i  in  32  correct next PC from EX.
- exc_valid_i  in  1  exception present in MEM.
- exc_cause_i  in  32  exception cause.
- exc_pc_i  in  32  PC of the excepting instruction.
- mret_i  in  1  mret retiring in MEM.
- mtvec_i  in  32  trap vector CSR.
- mepc_i  in  32  mepc CSR.
- stall_o  out  6  stall vector; bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB; 1 = Stop.
- flush_o  out  1  flush all pipeline registers.
- redirect_valid_o  out  1  one-cycle PC load strobe.
- redirect_pc_o  out  32  PC load value.
- trap_o  out  1  one-cycle strobe to the CSR file to latch the trap.
- trap_cause_o  out  32  cause to record.
- trap_epc_o  out  32  epc to record.

Behaviour:
- States: RUN, FLUSH. Internal 4-bit flush counter fcnt.
- Reset (rst_i=1 at clk edge): state=RUN, fcnt=0. While rst_i is high, all outputs are forced to 0.
- stall_o is combinational, zero latency, priority highest stage first:
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - if → 6'b000011
  - none → 6'b000000
  - This makes a requesting stage hold and the next register take a bubble.
- RUN, event priority (same cycle, combinational):
  - 1) mret_i & !stallreq_mem_i: flush_o=1, redirect_valid_o=1, redirect_pc_o=mepc_i, trap_o=0.
  - 2) exc_valid_i & !stallreq_mem_i: flush_o=1, redirect_valid_o=1, redirect_pc_o={mtvec_i[31:2],2'b00}, trap_o=1, trap_cause_o=exc_cause_i, trap_epc_o=exc_pc_i.
  - 3) branch_redirect_i & !stallreq_mem_i & !stallreq_ex_i: flush_o=1, redirect_valid_o=1, redirect_pc_o=branch_target_i.
  - While any event fires, stall_o=0; flush overrides stall.
- Exception or mret with stallreq_mem_i=1: not taken. The request is held upstream and taken in the first cycle the MEM stall clears.
- After any taken event with FLUSH_CYCLES>1: next state FLUSH, fcnt=FLUSH_CYCLES-2.
- FLUSH:
  - flush_o=1, stall_o=0, redirect_valid_o=0, trap_o=0.
  - Branch redirects are ignored.
  - fcnt decrements each cycle; at fcnt==0 go to RUN.
  - An exception or mret arriving in FLUSH is taken immediately as in RUN and reloads fcnt.
- With FLUSH_CYCLES==1 the block never leaves RUN; back-to-back events each produce a single-cycle flush.
- Inactive outputs:
  - redirect_pc_o=0 when redirect_valid_o=0.
  - trap_cause_o and trap_epc_o are 0 when trap_o=0.
- Reset mid-FLUSH returns to RUN the next cycle; outputs are 0 while rst_i is high.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined: three PERF_W-bit saturating counters with read-only outputs perf_stall_cyc_o, perf_flush_evt_o and perf_trap_evt_o.
  - perf_stall_cyc_o counts cycles with stall_o!=0.
  - perf_flush_evt_o counts redirect_valid_o pulses.
  - perf_trap_evt_o counts trap_o pulses.
  - All three clear on rst_i and saturate at all-ones.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package/defines: Stop/NoStop, stall vector encodings STALL_MEM/EX/ID/IF/NONE, state encodings, stall bit indices.
- One natural sub-module, pipe_ctrl_perf: the counter bank, instantiated only under PIPE_CTRL_PERF_EN.

Test Plan:
- stallreq_id_i=1 only → stall_o=6'b000111 same cycle; stallreq_mem_i also 1 → 6'b011111.
- branch_redirect_i=1, branch_target_i=32'h8000_0040, FLUSH_CYCLES=1 → one cycle flush_o=1, redirect_valid_o=1, redirect_pc_o=32'h8000_0040; next cycle both 0.
- exc_valid_i=1, exc_cause_i=2, exc_pc_i=32'h100, mtvec_i=32'h203, simultaneous branch_redirect_i → redirect_pc_o=32'h200, trap_o=1, trap_cause_o=2, trap_epc_o=32'h100; branch ignored.
- exc_valid_i=1 with stallreq_mem_i=1 for 3 cycles → flush_o=0, stall_o=6'b011111; on cycle 4 (stall clear) → trap_o=1.
- FLUSH_CYCLES=3, branch event → flush_o high exactly 3 cycles; a branch in cycle 2 is ignored; mret_i in cycle 2 with mepc_i=32'h400 → redirect_pc_o=32'h400 and flush extends to cycle 4.
- rst_i asserted during FLUSH → all outputs 0; after release, state RUN and stall_o=0; with PIPE_CTRL_PERF_EN defined, all counters read 0.
